// File: rtl/rx_frame_receiver.sv
// rx_frame_receiver: serial frame receiver with a valid/ready output hold stage.
// Frame: start(0), 7 data bits LSB first, even parity, stop(1).
// Each bit lasts CLKS_PER_BIT clocks.
// A completed frame is dropped with an overrun pulse when the previous one is still unaccepted.
module rx_frame_receiver #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       serial_in,
  input  logic       data_ready,
  output logic [6:0] data_out,
  output logic       data_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  // Mid-bit offset for the start sample, and the full-period terminal count after it.
  localparam logic [7:0] HALF_CNT = 8'(CLKS_PER_BIT / 2);
  localparam logic [7:0] LAST_CNT = 8'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_HIGH
  } state_t;

  state_t     state;
  logic       sync_1;
  logic       rx_s;
  logic [7:0] cnt;
  logic [2:0] bit_idx;
  logic [6:0] shift;
  logic       par_s;

  // Two-flop synchronizer; resets to the idle (high) line level.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_1 <= 1'b1;
      rx_s   <= 1'b1;
    end else begin
      sync_1 <= serial_in;
      rx_s   <= sync_1;
    end
  end

  // Receive FSM plus the output hold register.
  // A frame is delivered on the stop-sample edge.
  // It is dropped instead when the held frame is still pending.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      cnt        <= 8'd0;
      bit_idx    <= 3'd0;
      shift      <= 7'h00;
      par_s      <= 1'b0;
      data_out   <= 7'h00;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= 1'b0;
      // Consumer handshake; a frame completing this cycle overrides the clear below.
      if (data_valid && data_ready) begin
        data_valid <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state <= START;
            cnt   <= 8'd0;
          end
        end
        START: begin
          if (cnt == HALF_CNT) begin
            cnt     <= 8'd0;
            bit_idx <= 3'd0;
            // A line already back high by mid-start is a glitch; drop it silently.
            state   <= rx_s ? IDLE : DATA;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        DATA: begin
          if (cnt == LAST_CNT) begin
            cnt   <= 8'd0;
            // Shift right so the first received bit ends up in bit 0.
            shift <= {rx_s, shift[6:1]};
            if (bit_idx == 3'd6) begin
              state <= PARITY;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        PARITY: begin
          if (cnt == LAST_CNT) begin
            cnt   <= 8'd0;
            par_s <= (^shift) ^ rx_s;
            state <= STOP;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        STOP: begin
          if (cnt == LAST_CNT) begin
            cnt   <= 8'd0;
            // A low stop bit means a break or a framing fault; wait for the line to recover.
            state <= rx_s ? IDLE : WAIT_HIGH;
            if (!data_valid || data_ready) begin
              data_out   <= shift;
              parity_err <= par_s;
              frame_err  <= ~rx_s;
              data_valid <= 1'b1;
            end else begin
              overrun <= 1'b1;
            end
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        WAIT_HIGH: begin
          if (rx_s) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: doc/rx_frame_receiver.md
RX_FRAME_RECEIVER -- requirements
Module: rx_frame_receiver

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 4, meaning clock cycles per serial bit period, legal range 1 to 255.
REQ-002 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-003 SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port serial_in  input  1  serial line; idles high; asynchronous to clk.
REQ-005 SHALL have port data_ready  input  1  consumer accepts data_out when high together with data_valid.
REQ-006 SHALL have port data_out  output  7  received data bits; bit 0 first on the line.
REQ-007 SHALL have port data_valid  output  1  data_out, parity_err and frame_err hold a frame that has not been accepted.
REQ-008 SHALL have port parity_err  output  1  even-parity mismatch for the held frame.
REQ-009 SHALL have port frame_err  output  1  stop bit sampled low for the held frame.
REQ-010 SHALL have port overrun  output  1  one-cycle pulse: a completed frame was dropped.
REQ-011 SHALL have port busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-012 SHALL accept this frame format: start bit (0), 7 data bits LSB first, even parity bit, stop bit (1); each bit lasts CLKS_PER_BIT cycles.
REQ-013 SHALL pass serial_in through a 2-flop synchronizer reset to 1; all decoding uses the synchronized signal rx_s.
REQ-014 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP and WAIT_HIGH.
REQ-015 IDLE: on rx_s==0, SHALL enter START and clear the bit-period counter.
REQ-016 START: at counter value CLKS_PER_BIT/2 (integer division; 0 when CLKS_PER_BIT==1), SHALL sample rx_s; 1 -> glitch, return to IDLE, nothing reported; 0 -> enter DATA.
REQ-017 Sample points after the start sample SHALL be spaced exactly CLKS_PER_BIT cycles apart.
REQ-018 DATA: SHALL take 7 samples into data bits 0 through 6 in order, then enter PARITY.
REQ-019 PARITY: SHALL take 1 sample; parity error = XOR of the 7 data bits and the parity sample, nonzero means error.
REQ-020 STOP: SHALL take 1 sample; 0 sets frame error and goes to WAIT_HIGH; 1 goes to IDLE.
REQ-021 WAIT_HIGH: SHALL remain until rx_s==1, then enter IDLE; no start detection in this state.
REQ-022 On the cycle after the stop sample edge, if data_valid is low or data_ready is high, SHALL load data_out, parity_err and frame_err and assert data_valid.
REQ-023 If data_valid is high and data_ready is low when a frame completes, SHALL drop the new frame, keep the held outputs unchanged and pulse overrun high for 1 cycle.
REQ-024 SHALL deassert data_valid the cycle after data_valid && data_ready, unless a completing frame reloads it in that same cycle (REQ-022).
REQ-025 data_out, parity_err and frame_err SHALL remain stable while data_valid is high.
REQ-026 Errored frames (parity or framing) SHALL still be delivered with data_valid and the corresponding flag set.
REQ-027 A new start bit SHALL be detectable in the cycle IDLE is re-entered, so back-to-back frames with no idle gap are received.

Reset
REQ-028 While rstn is low, SHALL hold: FSM IDLE, counters 0, synchronizer 1, data_out 7'h00, data_valid 0, parity_err 0, frame_err 0, overrun 0, busy 0.
REQ-029 Reset asserted mid-frame SHALL abandon the partial frame with no report.
REQ-030 After reset release, SHALL require rx_s==0 observed in IDLE before any reception.

Verification
REQ-031 CLKS_PER_BIT=4, data_ready=1, send 7'h55 with parity 0 and stop 1 -> one data_valid with data_out=7'h55, parity_err=0, frame_err=0.
REQ-032 Send 7'h01 with parity bit 0 -> data_valid with data_out=7'h01, parity_err=1.
REQ-033 Send 7'h2A with correct parity and stop bit 0, then hold the line low for 20 cycles -> frame_err=1, busy stays high until the line returns high, no second frame reported.
REQ-034 Line low for 1 cycle only -> no data_valid, FSM returns to IDLE.
REQ-035 data_ready=0, two back-to-back frames 7'h11 then 7'h22 -> data_out stays 7'h11, overrun pulses once, data_valid drops 1 cycle after data_ready rises.
REQ-036 rstn pulsed low after data bit 3 of a frame -> all outputs at reset values, no data_valid; next complete frame 7'h7F is received correctly.
